vga_text_line: RTL and testbench
================================

# vga_text_line

Parametrised single-line text overlay for the VGA pipeline. Holds a writable buffer of NUM_CHARS 7-bit ASCII codes and places them at an arbitrary pixel origin, not just an 8/16-aligned one. It consumes the x/y/video_on/hsync/vsync stream from vga_sync and drives 12-bit rgb. Syncs are delayed to match a fixed 3-cycle render pipeline. It replaces per-character instances and priority decoders with one buffered, runtime-updatable line.

## Interface
- NUM_CHARS, 16: characters in the line, 1..64.
- X_ORIGIN, 80: left pixel column of character 0, 10-bit.
- Y_ORIGIN, 80: top pixel row of the line, 10-bit.
- FG_COLOR, 12'hFFF: glyph pixel colour.
- BG_COLOR, 12'h008: colour of every active pixel that is not a glyph pixel.
- BLINK_LOG2, 5: blink half-period is 2^BLINK_LOG2 frames. Used only with TEXT_BLINK_EN.
- clk, input, 1: pixel-rate clock, single clock domain.
- reset, input, 1: asynchronous, active-low.
- x, input, 10: current pixel column from vga_sync.
- y, input, 10: current pixel row from vga_sync.
- video_on, input, 1: active-area flag.
- hsync, input, 1: raw sync from vga_sync.
- vsync, input, 1: raw sync from vga_sync.
- wr_en, input, 1: write request.
- wr_addr, input, AW: character slot, where AW = max(1, clog2(NUM_CHARS)).
- wr_data, input, 8: [6:0] is the ASCII code. [7] is the blink attribute (see Configuration).
- wr_ready, output, 1: high when a write is accepted this cycle.
- hsync_o, output, 1: hsync delayed 3 cycles.
- vsync_o, output, 1: vsync delayed 3 cycles.
- rgb, output, 12: pixel colour, aligned with hsync_o and vsync_o.

## Operation
- Character buffer: NUM_CHARS × 8 bits, synchronous read. Not reset directly.
- Clear sequencer, states CLEAR and RUN:
  - Reset enters CLEAR with index 0.
  - CLEAR writes 8'h20 (space, no blink) to one slot per cycle.
  - After slot NUM_CHARS-1 it moves to RUN.
  - wr_ready = (state == RUN).
  - Reset asserted mid-clear restarts the clear from index 0.
- Write handshake: a write commits when wr_en && wr_ready.
  - wr_addr >= NUM_CHARS: dropped silently, no side effects.
  - Write and render read of the same slot in the same cycle: the render gets the old data. The new data is visible from the next cycle.
- Hit test (stage 1), using unsigned 10-bit subtraction:
  - dx = x - X_ORIGIN, dy = y - Y_ORIGIN.
  - hit = video_on && x >= X_ORIGIN && dx < NUM_CHARS*8 && y >= Y_ORIGIN && dy < 16.
  - Slot index = dx[9:3], glyph column = dx[2:0], glyph row = dy[3:0].
- Glyph fetch (stage 2): rom_addr = {code[6:0], row}, 11 bits, into ascii_rom (1-cycle latency).
- Pixel select (stage 3): bit = rom_data[7 - col].
  - rgb = !video_on_d ? 0 : (hit_d && bit && visible) ? FG_COLOR : BG_COLOR.
  - Without blink, visible is always 1.

## Timing
- Latency: inputs sampled in cycle t appear on rgb, hsync_o and vsync_o in cycle t+3. All three are registered outputs.
- Reset values:
  - rgb = 0, hsync_o = 1, vsync_o = 1, wr_ready = 0.
  - All pipeline valid/hit flags are 0. Frame counter is 0.
- wr_ready first rises NUM_CHARS cycles after reset deassertion.
- During CLEAR, rendering continues and shows whatever is currently in the buffer (spaces or stale data). There is no output glitch beyond the buffer content itself.
- Origin wrap: if X_ORIGIN + NUM_CHARS*8 > 1023, columns past 1023 never hit. There is no wrap to x = 0.

## Configuration
- TEXT_BLINK_EN defined:
  - A frame counter of BLINK_LOG2+1 bits increments on each vsync falling edge. The edge is detected on a registered copy of vsync.
  - Slots with attribute bit [7] = 1 are invisible (rendered as BG) while counter[BLINK_LOG2] = 1.
- TEXT_BLINK_EN undefined:
  - wr_data[7] is stored but ignored, there is no frame counter, and visible = 1.

## Structure
- Package vga_text_pkg holds:
  - CHAR_W = 8, CHAR_H = 16, RGB_W = 12, ASCII_W = 7.
  - SPACE_CODE = 7'h20.
  - The state encoding for CLEAR and RUN.
- One sub-module: the existing ascii_rom (clk, rom_addr[10:0], data[7:0]), instantiated once.
- Buffer, sequencer and pipeline stay in vga_text_line.

## Test plan
- Reset release, NUM_CHARS = 16:
  - wr_ready = 0 for 16 cycles, then 1.
  - Probing every slot via the rendered rows shows space glyphs, so rgb = BG in the region.
- Write 'F' (8'h46) to slot 0, X_ORIGIN = 80, Y_ORIGIN = 80:
  - Drive x = 80..87, y = 80..95.
  - rgb matches ascii_rom glyph 0x46 bit-for-bit (FG/BG), 3 cycles after each input.
- Unaligned origin X_ORIGIN = 83:
  - Pixel x = 83 maps to slot 0, column 0.
  - x = 82 and x = 83 + 128 give BG.
  - video_on = 0 gives rgb = 0.
- Write to wr_addr = 20 with NUM_CHARS = 16:
  - Buffer is unchanged.
  - Write to slot 3 in the same cycle that slot 3 renders: the old glyph shows on that pixel, the new glyph on the next character pass.
- Assert reset mid-clear at cycle 5:
  - After release, the clear restarts and wr_ready rises 16 cycles later.
  - The sync outputs return to 1.
- TEXT_BLINK_EN, BLINK_LOG2 = 1, slot 0 = 8'hC1:
  - 'A' is visible in frames 0–1, BG in frames 2–3, visible in frames 4–5.
  - A non-blink 'B' in slot 1 is always visible.

Source files
------------

// File: rtl/vga_text_pkg.sv
// ============================================================================
//  vga_text_pkg
//  Shared geometry constants, clear-sequencer states and pipeline stage types
//  for the vga_text_line overlay.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package vga_text_pkg;

  localparam int CHAR_W  = 8;
  localparam int CHAR_H  = 16;
  localparam int RGB_W   = 12;
  localparam int ASCII_W = 7;

  localparam logic [ASCII_W-1:0] SPACE_CODE = 7'h20;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic       von;
    logic       hit;
    logic [2:0] col;
    logic [3:0] row;
  } stage1_t;

  typedef struct packed {
    logic       von;
    logic       hit;
    logic [2:0] col;
  } stage2_t;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_text_line_if.sv
// ============================================================================
//  vga_text_line_if
//  Character-buffer write port: request/address/data from the master,
//  ready back from the overlay.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface vga_text_line_if #(
  parameter int AW = 4
) ();

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          wr_ready;

  modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);

endinterface

`default_nettype wire

// File: rtl/ascii_rom.sv
// ============================================================================
//  ascii_rom
//  8x16 glyph ROM, address {code[6:0], row[3:0]}, one-cycle registered read.
//  This build carries glyphs for space, 'A', 'B' and 'F'; others read blank.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module ascii_rom (
  input  logic        clk,
  input  logic [10:0] rom_addr,
  output logic [7:0]  data
);

  logic [7:0] data_d;
  logic [7:0] data_q;

  always_comb begin
    data_d = 8'h00;
    case (rom_addr)
      11'h412: data_d = 8'h10;
      11'h413: data_d = 8'h38;
      11'h414: data_d = 8'h6C;
      11'h415, 11'h416,
      11'h418, 11'h419,
      11'h41A, 11'h41B: data_d = 8'hC6;
      11'h417: data_d = 8'hFE;
      11'h422, 11'h42B: data_d = 8'hFC;
      11'h423, 11'h424, 11'h425,
      11'h427, 11'h428,
      11'h429, 11'h42A: data_d = 8'h66;
      11'h426: data_d = 8'h7C;
      11'h462: data_d = 8'hFE;
      11'h463, 11'h46A: data_d = 8'h66;
      11'h464, 11'h469: data_d = 8'h62;
      11'h465, 11'h467: data_d = 8'h68;
      11'h466: data_d = 8'h78;
      11'h468: data_d = 8'h60;
      11'h46B: data_d = 8'hF0;
      default: data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

`default_nettype wire

// File: rtl/vga_text_line.sv
// ============================================================================
//  vga_text_line
//  Single buffered text line overlay at an arbitrary pixel origin; 3-cycle
//  render pipeline with matching sync delay. Optional TEXT_BLINK_EN macro
//  enables per-character blink driven by a vsync frame counter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module vga_text_line
  import vga_text_pkg::*;
#(
  parameter int               NUM_CHARS  = 16,
  parameter logic [9:0]       X_ORIGIN   = 10'd80,
  parameter logic [9:0]       Y_ORIGIN   = 10'd80,
  parameter logic [RGB_W-1:0] FG_COLOR   = 12'hFFF,
  parameter logic [RGB_W-1:0] BG_COLOR   = 12'h008,
  parameter int               BLINK_LOG2 = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       x,
  input  logic [9:0]       y,
  input  logic             video_on,
  input  logic             hsync,
  input  logic             vsync,
  vga_text_line_if.slave   wr_bus,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic [RGB_W-1:0] rgb
);

  localparam int AW     = addr_w(NUM_CHARS);
  localparam int LINE_W = NUM_CHARS * CHAR_W;

  seq_state_e       state_q, state_d;
  logic [AW-1:0]    clr_idx_q, clr_idx_d;

  logic [7:0]       mem_q [NUM_CHARS];
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [7:0]       mem_wdata;
  logic             wr_in_range;

  logic [9:0]       dx, dy;
  logic             hit;
  logic [AW-1:0]    rd_addr;
  logic [7:0]       rd_data_q;

  stage1_t          s1_q, s1_d;
  stage2_t          s2_q, s2_d;
  logic [2:0]       hs_pipe_q, hs_pipe_d;
  logic [2:0]       vs_pipe_q, vs_pipe_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;

  logic [10:0]      rom_addr;
  logic [7:0]       rom_data;
  logic             pix_bit;
  logic             visible;

  // Clear sequencer owns the buffer write port until every slot holds a space.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == ST_CLEAR) begin
      if (clr_idx_q == AW'(NUM_CHARS - 1)) begin
        state_d = ST_RUN;
      end else begin
        clr_idx_d = clr_idx_q + 1'b1;
      end
    end
  end

  assign wr_bus.wr_ready = (state_q == ST_RUN);
  assign wr_in_range     = (int'(wr_bus.wr_addr) < NUM_CHARS);

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_idx_q;
      mem_wdata = {1'b0, SPACE_CODE};
    end else if (wr_bus.wr_en && wr_in_range) begin
      mem_we    = 1'b1;
      mem_waddr = wr_bus.wr_addr;
      mem_wdata = wr_bus.wr_data;
    end
  end

  // Unsigned wrap of dx/dy makes pixels left of / above the origin miss.
  always_comb begin
    dx      = x - X_ORIGIN;
    dy      = y - Y_ORIGIN;
    hit     = video_on && (x >= X_ORIGIN) && ({1'b0, dx} < 11'(LINE_W)) &&
              (y >= Y_ORIGIN) && (dy < 10'(CHAR_H));
    rd_addr = hit ? dx[3 +: AW] : '0;
  end

  // Read-before-write: a same-cycle write is seen by the render one cycle later.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  always_comb begin
    s1_d.von  = video_on;
    s1_d.hit  = hit;
    s1_d.col  = dx[2:0];
    s1_d.row  = dy[3:0];
    s2_d.von  = s1_q.von;
    s2_d.hit  = s1_q.hit;
    s2_d.col  = s1_q.col;
    rom_addr  = {rd_data_q[ASCII_W-1:0], s1_q.row};
    hs_pipe_d = {hs_pipe_q[1:0], hsync};
    vs_pipe_d = {vs_pipe_q[1:0], vsync};
    pix_bit   = rom_data[3'd7 - s2_q.col];
    rgb_d     = !s2_q.von ? '0 :
                (s2_q.hit && pix_bit && visible) ? FG_COLOR : BG_COLOR;
  end

  ascii_rom u_rom (
    .clk      (clk),
    .rom_addr (rom_addr),
    .data     (rom_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      hs_pipe_q <= 3'b111;
      vs_pipe_q <= 3'b111;
      rgb_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      hs_pipe_q <= hs_pipe_d;
      vs_pipe_q <= vs_pipe_d;
      rgb_q     <= rgb_d;
    end
  end

`ifdef TEXT_BLINK_EN
  logic [BLINK_LOG2:0] frame_q, frame_d;
  logic                blink2_q, blink2_d;

  // Frame counter steps on the vsync falling edge seen against its registered copy.
  always_comb begin
    frame_d  = frame_q;
    if (vs_pipe_q[0] && !vsync) begin
      frame_d = frame_q + 1'b1;
    end
    blink2_d = rd_data_q[7];
    visible  = !(blink2_q && frame_q[BLINK_LOG2]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_q  <= '0;
      blink2_q <= 1'b0;
    end else begin
      frame_q  <= frame_d;
      blink2_q <= blink2_d;
    end
  end
`else
  logic blink_unused;
  assign blink_unused = ^{rd_data_q[7], BLINK_LOG2[0]};
  assign visible      = 1'b1;
`endif

  assign hsync_o = hs_pipe_q[2];
  assign vsync_o = vs_pipe_q[2];
  assign rgb     = rgb_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_text_line.sv
// ============================================================================
//  tb_vga_text_line
//  Directed bench: dut0 (16 chars @ x=80) and dut1 (12 chars @ x=83).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vga_text_line;

  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h008;
  localparam logic [127:0] GLYPH_A = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
  localparam logic [127:0] GLYPH_B = 128'h0000_FC66_6666_7C66_6666_66FC_0000_0000;
  localparam logic [127:0] GLYPH_F = 128'h0000_FE66_6268_7868_6062_66F0_0000_0000;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x, y;
  logic       video_on, hsync, vsync;
  logic       hsync_o0, vsync_o0, hsync_o1, vsync_o1;
  logic [11:0] rgb0, rgb1;

  logic [7:0] mb0 [16];
  logic [7:0] mb1 [16];
  int total = 0;
  int bad   = 0;

  vga_text_line_if #(.AW(4)) bus0 ();
  vga_text_line_if #(.AW(4)) bus1 ();

  vga_text_line #(.NUM_CHARS(16), .X_ORIGIN(10'd80), .Y_ORIGIN(10'd80),
                  .FG_COLOR(FG), .BG_COLOR(BG), .BLINK_LOG2(1)) dut0 (
    .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on),
    .hsync(hsync), .vsync(vsync), .wr_bus(bus0),
    .hsync_o(hsync_o0), .vsync_o(vsync_o0), .rgb(rgb0));

  vga_text_line #(.NUM_CHARS(12), .X_ORIGIN(10'd83), .Y_ORIGIN(10'd80),
                  .FG_COLOR(FG), .BG_COLOR(BG), .BLINK_LOG2(1)) dut1 (
    .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on),
    .hsync(hsync), .vsync(vsync), .wr_bus(bus1),
    .hsync_o(hsync_o1), .vsync_o(vsync_o1), .rgb(rgb1));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] glyph_row(input logic [7:0] code, input int r);
    logic [127:0] g;
    case (code[6:0])
      7'h41:   g = GLYPH_A;
      7'h42:   g = GLYPH_B;
      7'h46:   g = GLYPH_F;
      default: g = '0;
    endcase
    return g[127 - 8*r -: 8];
  endfunction

  function automatic logic [11:0] exp_rgb(input int px, input int py, input logic von,
                                          input int org, input int n, input logic [7:0] mb [16]);
    logic [7:0] row;
    int rel;
    if (!von) return 12'h000;
    if (px < org || px - org >= n * 8 || py < 80 || py - 80 >= 16) return BG;
    rel = px - org;
    row = glyph_row(mb[rel / 8], py - 80);
    return row[7 - (rel % 8)] ? FG : BG;
  endfunction

  // Presents one pixel, lets any pending write fire on the first edge, waits out the pipeline.
  task automatic probe(input int px, input int py, input logic von);
    x = px[9:0];
    y = py[9:0];
    video_on = von;
    tick();
    bus0.wr_en = 1'b0;
    bus1.wr_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic pix(input string tag, input int px, input int py, input logic von);
    logic [11:0] e0, e1;
    e0 = exp_rgb(px, py, von, 80, 16, mb0);
    e1 = exp_rgb(px, py, von, 83, 12, mb1);
    probe(px, py, von);
    chk({tag, "/d0"}, 32'(rgb0), 32'(e0));
    chk({tag, "/d1"}, 32'(rgb1), 32'(e1));
  endtask

  task automatic arm_write(input int a, input logic [7:0] d);
    bus0.wr_en = 1'b1; bus0.wr_addr = a[3:0]; bus0.wr_data = d;
    bus1.wr_en = 1'b1; bus1.wr_addr = a[3:0]; bus1.wr_data = d;
  endtask

  task automatic model_write(input int a, input logic [7:0] d);
    if (a < 16) mb0[a] = d;
    if (a < 12) mb1[a] = d;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    arm_write(a, d);
    tick();
    bus0.wr_en = 1'b0;
    bus1.wr_en = 1'b0;
    model_write(a, d);
  endtask

  task automatic spaces();
    for (int i = 0; i < 16; i++) begin
      mb0[i] = 8'h20;
      mb1[i] = 8'h20;
    end
  endtask

  initial begin
    reset = 1'b0; x = '0; y = '0; video_on = 1'b0; hsync = 1'b1; vsync = 1'b1;
    bus0.wr_en = 1'b0; bus0.wr_addr = '0; bus0.wr_data = '0;
    bus1.wr_en = 1'b0; bus1.wr_addr = '0; bus1.wr_data = '0;
    spaces();
    tick(); tick(); tick();

    chk("rst_rgb0", 32'(rgb0), 32'h0);
    chk("rst_rgb1", 32'(rgb1), 32'h0);
    chk("rst_hs0", 32'(hsync_o0), 32'h1);
    chk("rst_vs0", 32'(vsync_o0), 32'h1);
    chk("rst_rdy0", 32'(bus0.wr_ready), 32'h0);
    chk("rst_rdy1", 32'(bus1.wr_ready), 32'h0);

    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("clr_rdy0", 32'(bus0.wr_ready), 32'h0);
      chk("clr_rdy1", 32'(bus1.wr_ready), 32'(i >= 12));
      tick();
    end
    chk("run_rdy0", 32'(bus0.wr_ready), 32'h1);

    for (int s = 0; s < 16; s++) pix("space", 80 + 8*s + 2, 84, 1'b1);

    // Sync and pixel latency: exactly three edges.
    hsync = 1'b0; vsync = 1'b0; tick();
    hsync = 1'b1; vsync = 1'b1;
    chk("hs_lat1", 32'(hsync_o0), 32'h1);
    tick();
    chk("hs_lat2", 32'(hsync_o0), 32'h1);
    chk("vs_lat2", 32'(vsync_o1), 32'h1);
    tick();
    chk("hs_lat3", 32'(hsync_o0), 32'h0);
    chk("vs_lat3", 32'(vsync_o0), 32'h0);
    chk("hs1_lat3", 32'(hsync_o1), 32'h0);
    tick();
    chk("hs_lat4", 32'(hsync_o0), 32'h1);
    video_on = 1'b0; tick(); tick(); tick();
    x = 10'd80; y = 10'd84; video_on = 1'b1;
    tick(); tick();
    chk("rgb_lat2", 32'(rgb0), 32'h0);
    tick();
    chk("rgb_lat3", 32'(rgb0), 32'(BG));

    wr(0, 8'h46);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 8; c++)
        pix("glyphF", 80 + c, 80 + r, 1'b1);

    wr(11, 8'h42);
    wr(15, 8'h42);
    pix("x79", 79, 82, 1'b1);
    pix("x82", 82, 82, 1'b1);
    pix("x83", 83, 82, 1'b1);
    pix("x178", 178, 84, 1'b1);
    pix("x179", 179, 84, 1'b1);
    pix("x207", 207, 84, 1'b1);
    pix("x208", 208, 82, 1'b1);
    pix("x211", 211, 82, 1'b1);
    pix("y79", 83, 79, 1'b1);
    pix("y96", 83, 96, 1'b1);
    pix("von0", 83, 82, 1'b0);

    wr(13, 8'h46);
    for (int s = 0; s < 12; s++) pix("oob_keep", 83 + 8*s, 82, 1'b1);
    pix("slot13", 80 + 13*8, 82, 1'b1);

    wr(3, 8'h46);
    arm_write(3, 8'h41);
    pix("same_cyc", 104, 82, 1'b1);
    model_write(3, 8'h41);
    pix("next_pass", 104, 82, 1'b1);
    pix("d1_slot3", 107, 82, 1'b1);

    // Reset mid-clear restarts the sequencer from slot 0.
    reset = 1'b0; tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    hsync = 1'b0; vsync = 1'b0; reset = 1'b0;
    tick();
    chk("mid_hs0", 32'(hsync_o0), 32'h1);
    chk("mid_vs0", 32'(vsync_o0), 32'h1);
    chk("mid_rgb0", 32'(rgb0), 32'h0);
    chk("mid_rdy0", 32'(bus0.wr_ready), 32'h0);
    tick();
    hsync = 1'b1; vsync = 1'b1; reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("re_rdy0", 32'(bus0.wr_ready), 32'h0);
      tick();
    end
    chk("re_run0", 32'(bus0.wr_ready), 32'h1);
    chk("re_hs0", 32'(hsync_o0), 32'h1);
    chk("re_vs0", 32'(vsync_o0), 32'h1);
    spaces();
    pix("re_clr0", 80, 82, 1'b1);
    pix("re_clr3", 104, 82, 1'b1);
    pix("re_clr15", 200, 82, 1'b1);

`ifdef TEXT_BLINK_EN
    wr(0, 8'hC1);
    wr(1, 8'h42);
    for (int f = 0; f < 6; f++) begin
      probe(83, 82, 1'b1);
      chk("blinkA", 32'(rgb0), 32'((f == 2 || f == 3) ? BG : FG));
      probe(88, 82, 1'b1);
      chk("steadyB", 32'(rgb0), 32'(FG));
      vsync = 1'b0; tick();
      vsync = 1'b1; tick();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
